// File: rtl/ns_gnrl_pkg.sv
// Shared types for the generic round-robin packet mux: FSM encoding and FIFO depth.
package ns_gnrl_pkg;

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_e;

    localparam int unsigned FIFO_DEPTH = 2;

    // True when exactly one bit is set; callers zero-extend vectors up to 32 bits.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

endpackage

// File: rtl/ns_gnrl_rrobin_pktmux_if.sv
// Ingress, arbiter and egress signals of the packet mux, bundled with directional modports.
interface ns_gnrl_rrobin_pktmux_if #(
    parameter int unsigned PORT_NUM = 4,
    parameter int unsigned DW       = 32
);
    localparam int unsigned SW = $clog2(PORT_NUM);

    logic [PORT_NUM-1:0]    in_vld;
    logic [PORT_NUM-1:0]    in_rdy;
    logic [PORT_NUM*DW-1:0] in_dat;
    logic [PORT_NUM-1:0]    in_last;
    logic [PORT_NUM-1:0]    req_vec;
    logic                   arbt_ena;
    logic [PORT_NUM-1:0]    grt_vec;
    logic                   out_vld;
    logic                   out_rdy;
    logic [DW-1:0]          out_dat;
    logic                   out_last;
    logic [SW-1:0]          out_src;
    logic                   err_grant;

    // Environment side: sources, arbiter grant and downstream ready.
    modport master (
        output in_vld, in_dat, in_last, grt_vec, out_rdy,
        input  in_rdy, req_vec, arbt_ena, out_vld, out_dat, out_last, out_src, err_grant
    );

    modport slave (
        input  in_vld, in_dat, in_last, grt_vec, out_rdy,
        output in_rdy, req_vec, arbt_ena, out_vld, out_dat, out_last, out_src, err_grant
    );

endinterface

// File: rtl/ns_gnrl_fifo2.sv
// Two-entry FIFO; in_rdy of the parent is derived from full_o alone.
module ns_gnrl_fifo2
    import ns_gnrl_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdat_i,
    output logic [W-1:0] rdat_o,
    output logic         full_o,
    output logic         nempty_o
);

    logic [W-1:0] mem_q [FIFO_DEPTH];
    logic         wptr_q, wptr_d;
    logic         rptr_q, rptr_d;
    logic [1:0]   cnt_q, cnt_d;

    always_comb begin
        wptr_d = wptr_q ^ push_i;
        rptr_d = rptr_q ^ pop_i;
        cnt_d  = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(FIFO_DEPTH); k++) mem_q[k] <= '0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (push_i) mem_q[wptr_q] <= wdat_i;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rdat_o   = mem_q[rptr_q];
    assign full_o   = (cnt_q == 2'(FIFO_DEPTH));
    assign nempty_o = (cnt_q != 2'd0);

endmodule

// File: rtl/ns_gnrl_rrobin_pktmux.sv
// N:1 packet mux: per-port FIFOs, external round-robin arbiter, packet lock and a
// registered valid/ready output stage.
module ns_gnrl_rrobin_pktmux
    import ns_gnrl_pkg::*;
#(
    parameter int unsigned PORT_NUM = 4,
    parameter int unsigned DW       = 32
) (
    input logic                      clk,
    input logic                      rst,
    ns_gnrl_rrobin_pktmux_if.slave   bus
);

    localparam int unsigned SW = $clog2(PORT_NUM);

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          last;
    } beat_t;

    logic [PORT_NUM-1:0] fifo_full, fifo_nempty, push, pop, req;
    beat_t               fifo_rdat [PORT_NUM];
    logic                can_load, load, gnt_ok, viol;
    logic [SW-1:0]       gnt_idx, sel_idx;

    state_e        state_q, state_d;
    logic [SW-1:0] owner_q, owner_d;
    logic          out_vld_q, out_vld_d;
    beat_t         out_beat_q, out_beat_d;
    logic [SW-1:0] out_src_q, out_src_d;
    logic          err_q, err_d;

    for (genvar i = 0; i < PORT_NUM; i++) begin : g_port
        ns_gnrl_fifo2 #(.W($bits(beat_t))) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push_i   (push[i]),
            .pop_i    (pop[i]),
            .wdat_i   ({bus.in_dat[i*DW +: DW], bus.in_last[i]}),
            .rdat_o   (fifo_rdat[i]),
            .full_o   (fifo_full[i]),
            .nempty_o (fifo_nempty[i])
        );
    end

    assign bus.in_rdy = ~fifo_full;
    assign push       = bus.in_vld & ~fifo_full;

    // Kept apart from the grant logic so req_vec never depends on grt_vec.
    assign can_load     = ~out_vld_q | bus.out_rdy;
    assign req          = (state_q == ST_IDLE) ? (fifo_nempty & {PORT_NUM{can_load}}) : '0;
    assign bus.req_vec  = req;
    assign bus.arbt_ena = |req;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < int'(PORT_NUM); i++) begin
            if (bus.grt_vec[i]) gnt_idx = SW'(i);
        end

        gnt_ok  = 1'b0;
        viol    = 1'b0;
        pop     = '0;
        sel_idx = owner_q;
        state_d = state_q;
        owner_d = owner_q;

        if (state_q == ST_IDLE) begin
            if (req != '0) begin
                gnt_ok = is_onehot(32'(bus.grt_vec)) && ((bus.grt_vec & ~req) == '0);
                viol   = ~gnt_ok;
            end else begin
                viol = |bus.grt_vec;
            end
            if (gnt_ok) begin
                pop     = bus.grt_vec;
                sel_idx = gnt_idx;
                if (!fifo_rdat[gnt_idx].last) begin
                    state_d = ST_LOCK;
                    owner_d = gnt_idx;
                end
            end
        end else if (can_load && fifo_nempty[owner_q]) begin
            pop[owner_q] = 1'b1;
            if (fifo_rdat[owner_q].last) state_d = ST_IDLE;
        end

        load       = |pop;
        out_vld_d  = load | (out_vld_q & ~bus.out_rdy);
        out_beat_d = load ? fifo_rdat[sel_idx] : out_beat_q;
        out_src_d  = load ? sel_idx : out_src_q;
        err_d      = err_q | viol;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            out_vld_q  <= 1'b0;
            out_beat_q <= '0;
            out_src_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            out_vld_q  <= out_vld_d;
            out_beat_q <= out_beat_d;
            out_src_q  <= out_src_d;
            err_q      <= err_d;
        end
    end

    assign bus.out_vld   = out_vld_q;
    assign bus.out_dat   = out_beat_q.dat;
    assign bus.out_last  = out_beat_q.last;
    assign bus.out_src   = out_src_q;
    assign bus.err_grant = err_q;

endmodule

// File: tb/tb_ns_gnrl_rrobin_pktmux.sv
// Directed bench for ns_gnrl_rrobin_pktmux with a behavioural round-robin arbiter.
module tb_ns_gnrl_rrobin_pktmux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    ns_gnrl_rrobin_pktmux_if #(.PORT_NUM(4), .DW(32)) bus ();

    ns_gnrl_rrobin_pktmux #(.PORT_NUM(4), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Arbiter: first request at or after the pointer; pointer moves past the winner.
    int         arb_ptr;
    logic [3:0] arb_gnt;
    logic       force_en  = 1'b0;
    logic [3:0] force_val = 4'b0;
    int         ena_cnt   = 0;

    always_comb begin
        arb_gnt = '0;
        for (int k = 0; k < 4; k++) begin
            if (bus.req_vec[(arb_ptr + k) % 4] && arb_gnt == 4'b0) arb_gnt[(arb_ptr + k) % 4] = 1'b1;
        end
        bus.grt_vec = force_en ? force_val : arb_gnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_ptr <= 0;
        end else if (bus.arbt_ena && arb_gnt != 4'b0) begin
            for (int k = 0; k < 4; k++) if (arb_gnt[k]) arb_ptr <= (k + 1) % 4;
        end
    end

    always_ff @(posedge clk) if (bus.arbt_ena) ena_cnt <= ena_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_beat(input int p, input logic [31:0] d, input logic l);
        bus.in_dat[p*32 +: 32] = d;
        bus.in_last[p]         = l;
    endtask

    initial begin
        int e0;
        int cnt [4];
        int beats, ncyc, rot_err, dat_err, exp_src;

        bus.in_vld  = '0;
        bus.in_dat  = '0;
        bus.in_last = '0;
        bus.out_rdy = 1'b0;

        // Reset values
        #2;
        chk("rst_out_vld", 32'(bus.out_vld), 0);
        chk("rst_out_dat", bus.out_dat, 0);
        chk("rst_out_src", 32'(bus.out_src), 0);
        chk("rst_out_last", 32'(bus.out_last), 0);
        chk("rst_err", 32'(bus.err_grant), 0);
        chk("rst_in_rdy", 32'(bus.in_rdy), 32'hF);
        chk("rst_req", 32'(bus.req_vec), 0);
        tick();
        tick();
        rst = 1'b0;

        // Single beat from port 2
        tick();
        bus.out_rdy = 1'b1;
        set_beat(2, 32'hA5, 1'b1);
        bus.in_vld = 4'b0100;
        e0 = ena_cnt;
        #1 chk("sb_req_empty", 32'(bus.req_vec), 0);
        tick();
        bus.in_vld = 4'b0;
        #1 chk("sb_req", 32'(bus.req_vec), 32'h4);
        chk("sb_ena", 32'(bus.arbt_ena), 1);
        tick();
        #1 chk("sb_vld", 32'(bus.out_vld), 1);
        chk("sb_dat", bus.out_dat, 32'hA5);
        chk("sb_src", 32'(bus.out_src), 2);
        chk("sb_last", 32'(bus.out_last), 1);
        chk("sb_ena_off", 32'(bus.arbt_ena), 0);
        tick();
        chk("sb_vld_off", 32'(bus.out_vld), 0);
        chk("sb_ena_once", 32'(ena_cnt - e0), 1);

        // Packet lock: pointer now sits on port 3, so port 0 beats port 1
        set_beat(0, 32'h10, 1'b0);
        set_beat(1, 32'h20, 1'b1);
        bus.in_vld = 4'b0011;
        tick();
        set_beat(0, 32'h11, 1'b0);
        bus.in_vld = 4'b0001;
        #1 chk("pl_req", 32'(bus.req_vec), 32'h3);
        tick();
        set_beat(0, 32'h12, 1'b1);
        #1 chk("pl_dat0", bus.out_dat, 32'h10);
        chk("pl_src0", 32'(bus.out_src), 0);
        chk("pl_last0", 32'(bus.out_last), 0);
        chk("pl_lock_req0", 32'(bus.req_vec), 0);
        tick();
        bus.in_vld = 4'b0;
        #1 chk("pl_dat1", bus.out_dat, 32'h11);
        chk("pl_lock_req1", 32'(bus.req_vec), 0);
        tick();
        chk("pl_dat2", bus.out_dat, 32'h12);
        chk("pl_last2", 32'(bus.out_last), 1);
        chk("pl_req_unlock", 32'(bus.req_vec), 32'h2);
        tick();
        chk("pl_dat3", bus.out_dat, 32'h20);
        chk("pl_src3", 32'(bus.out_src), 1);
        tick();
        chk("pl_vld_off", 32'(bus.out_vld), 0);

        // Backpressure on port 3 for 5 cycles
        bus.out_rdy = 1'b0;
        set_beat(3, 32'h30, 1'b1);
        bus.in_vld = 4'b1000;
        tick();
        set_beat(3, 32'h31, 1'b1);
        tick();
        set_beat(3, 32'h32, 1'b1);
        #1 chk("bp_dat_a", bus.out_dat, 32'h30);
        chk("bp_rdy_a", 32'(bus.in_rdy[3]), 1);
        tick();
        set_beat(3, 32'h33, 1'b1);
        #1 chk("bp_rdy_low", 32'(bus.in_rdy[3]), 0);
        chk("bp_dat_b", bus.out_dat, 32'h30);
        tick();
        chk("bp_dat_c", bus.out_dat, 32'h30);
        chk("bp_rdy_low2", 32'(bus.in_rdy[3]), 0);
        tick();
        chk("bp_dat_d", bus.out_dat, 32'h30);
        chk("bp_vld_d", 32'(bus.out_vld), 1);
        bus.out_rdy = 1'b1;
        bus.in_vld  = 4'b0;
        #1 chk("bp_req_release", 32'(bus.req_vec), 32'h8);
        tick();
        chk("bp_dat_e", bus.out_dat, 32'h31);
        chk("bp_rdy_back", 32'(bus.in_rdy[3]), 1);
        tick();
        chk("bp_dat_f", bus.out_dat, 32'h32);
        chk("bp_vld_f", 32'(bus.out_vld), 1);
        tick();
        chk("bp_vld_off", 32'(bus.out_vld), 0);
        chk("bp_req_off", 32'(bus.req_vec), 0);

        // Fairness: every port streams single-beat packets; payload encodes the port
        for (int p = 0; p < 4; p++) begin
            set_beat(p, 32'h40 + 32'(p), 1'b1);
            cnt[p] = 0;
        end
        bus.in_vld = 4'hF;
        beats = 0; ncyc = 0; rot_err = 0; dat_err = 0; exp_src = 0;
        while (ncyc < 450 && beats < 400) begin
            tick();
            ncyc++;
            if (bus.out_vld) begin
                if (int'(bus.out_src) != exp_src) rot_err++;
                if (bus.out_dat != 32'h40 + 32'(bus.out_src)) dat_err++;
                cnt[bus.out_src]++;
                exp_src = (int'(bus.out_src) + 1) % 4;
                beats++;
            end
        end
        bus.in_vld = 4'b0;
        chk("fr_beats", 32'(beats), 400);
        chk("fr_cycles", 32'(ncyc), 401);
        chk("fr_rotation", 32'(rot_err), 0);
        chk("fr_payload", 32'(dat_err), 0);
        for (int p = 0; p < 4; p++) chk($sformatf("fr_share%0d", p), 32'(cnt[p] >= 99 && cnt[p] <= 101), 1);
        repeat (12) tick();
        chk("fr_drained", 32'(bus.out_vld), 0);
        chk("fr_req_off", 32'(bus.req_vec), 0);

        // Grant error: grant covers two requesters
        set_beat(1, 32'h61, 1'b1);
        set_beat(2, 32'h62, 1'b1);
        bus.in_vld = 4'b0110;
        tick();
        bus.in_vld = 4'b0;
        force_val  = 4'b0110;
        force_en   = 1'b1;
        #1 chk("ge_req", 32'(bus.req_vec), 32'h6);
        chk("ge_err_pre", 32'(bus.err_grant), 0);
        tick();
        force_en = 1'b0;
        #1 chk("ge_err", 32'(bus.err_grant), 1);
        chk("ge_no_load", 32'(bus.out_vld), 0);
        chk("ge_no_pop", 32'(bus.req_vec), 32'h6);
        repeat (4) tick();
        chk("ge_sticky", 32'(bus.err_grant), 1);
        chk("ge_req_drained", 32'(bus.req_vec), 0);

        // Reset mid-packet: 4-beat packet from port 0, reset with beat 2 on the output
        set_beat(0, 32'h50, 1'b0);
        bus.in_vld = 4'b0001;
        tick();
        set_beat(0, 32'h51, 1'b0);
        tick();
        set_beat(0, 32'h52, 1'b0);
        tick();
        chk("rm_beat2", bus.out_dat, 32'h51);
        rst        = 1'b1;
        bus.in_vld = 4'b0;
        #1 chk("rm_vld", 32'(bus.out_vld), 0);
        chk("rm_dat", bus.out_dat, 0);
        chk("rm_last", 32'(bus.out_last), 0);
        chk("rm_err", 32'(bus.err_grant), 0);
        chk("rm_in_rdy", 32'(bus.in_rdy), 32'hF);
        chk("rm_req", 32'(bus.req_vec), 0);
        tick();
        rst = 1'b0;
        set_beat(3, 32'h77, 1'b1);
        bus.in_vld = 4'b1000;
        tick();
        bus.in_vld = 4'b0;
        #1 chk("rm_new_req", 32'(bus.req_vec), 32'h8);
        tick();
        chk("rm_new_vld", 32'(bus.out_vld), 1);
        chk("rm_new_dat", bus.out_dat, 32'h77);
        chk("rm_new_src", 32'(bus.out_src), 3);
        chk("rm_new_last", 32'(bus.out_last), 1);
        tick();
        chk("rm_new_done", 32'(bus.out_vld), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
